// File: rtl/mcu_rstclk_ctrl.sv
// mcu_rstclk_ctrl: AHB-Lite system reset/clock controller.
// Boot remap, sticky reset cause, PLL enable/lock/switch sequencer.
module mcu_rstclk_ctrl #(
  parameter int ADDR_W       = 12,
  parameter int NUM_RST_SRC  = 3,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int LOCK_STABLE  = 4
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL,
  input  logic                   HREADY,
  input  logic                   HWRITE,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HSIZE,
  input  logic [ADDR_W-1:0]      HADDR,
  input  logic [31:0]            HWDATA,
  output logic                   HREADYOUT,
  output logic                   HRESP,
  output logic [31:0]            HRDATA,
  input  logic                   CFG_BOOT,
  input  logic [NUM_RST_SRC-1:0] RST_SRC,
  input  logic                   PLL_LOCK,
  output logic                   PLL_EN,
  output logic                   CLK_SEL,
  output logic                   REMAP,
  output logic                   IRQ
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int STB_W = $clog2(LOCK_STABLE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_LOCKING = 3'd1,
    ST_LOCKED  = 3'd2,
    ST_RUN     = 3'd3,
    ST_FAIL    = 3'd4
  } state_e;

  logic                   act_q, act_d;
  logic                   wr_q, wr_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [2:0]             size_q, size_d;
  logic                   boot_done_q, boot_done_d;
  logic                   remap_q, remap_d;
  logic [NUM_RST_SRC-1:0] rstinfo_q, rstinfo_d;
  logic                   pllon_q, pllon_d;
  logic                   swreq_q, swreq_d;
  logic                   timeout_q, timeout_d;
  logic                   lockloss_q, lockloss_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STB_W-1:0]       stb_q, stb_d;
  logic                   pll_en_q, pll_en_d;
  logic                   clk_sel_q, clk_sel_d;
  logic                   irq_q, irq_d;

  logic                   lock_s;
  logic                   we, rd;
  logic [3:0]             be;
  logic [ADDR_W-3:0]      widx;
  logic                   sel_remap, sel_rst, sel_ctl, sel_stat;
  logic [15:0]            rst_w1c16;
  logic [NUM_RST_SRC-1:0] rst_clr;
  logic                   set_to, set_ll;
  logic                   unused_ok;

  assign lock_s    = sync2_q;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign PLL_EN    = pll_en_q;
  assign CLK_SEL   = clk_sel_q;
  assign REMAP     = remap_q;
  assign IRQ       = irq_q;

  // Capture the address phase of a valid transfer
  always_comb begin
    act_d  = HSEL & HREADY & HTRANS[1];
    wr_d   = HWRITE;
    addr_d = HADDR;
    size_d = HSIZE;
  end

  assign we   = act_q & wr_q;
  assign rd   = act_q & ~wr_q;
  assign widx = addr_q[ADDR_W-1:2];

  assign sel_remap = (widx == (ADDR_W-2)'(0));
  assign sel_rst   = (widx == (ADDR_W-2)'(1));
  assign sel_ctl   = (widx == (ADDR_W-2)'(2));
  assign sel_stat  = (widx == (ADDR_W-2)'(3));

  // Byte lanes of the data phase from registered size/address
  always_comb begin
    be = 4'b1111;
    if (size_q == 3'd0) begin
      be = 4'b0001 << addr_q[1:0];
    end else if (size_q == 3'd1) begin
      be = addr_q[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign rst_w1c16 = HWDATA[15:0] & {{8{be[1]}}, {8{be[0]}}};
  assign rst_clr   = (we && sel_rst) ? rst_w1c16[NUM_RST_SRC-1:0] : '0;
  assign unused_ok = ^{HTRANS[0], HWDATA, rst_w1c16, be};

  // Read mux from the registered data-phase address
  always_comb begin
    HRDATA = '0;
    if (rd) begin
      unique case (1'b1)
        sel_remap: HRDATA = {31'd0, remap_q};
        sel_rst:   HRDATA = 32'(rstinfo_q);
        sel_ctl:   HRDATA = {23'd0, swreq_q, 7'd0, pllon_q};
        sel_stat:  HRDATA = {22'd0, lockloss_q, timeout_q, 3'd0,
                             state_q, clk_sel_q, lock_s};
        default:   HRDATA = '0;
      endcase
    end
  end

  // PLL sequencer next state, lock/timeout counters
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    stb_d   = '0;
    set_to  = 1'b0;
    set_ll  = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (pllon_q) state_d = ST_LOCKING;
      end
      ST_LOCKING: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        if (lock_s) begin
          stb_d = (stb_q == '1) ? stb_q : stb_q + STB_W'(1);
        end
        if (!pllon_q) begin
          state_d = ST_OFF;
        end else if (lock_s && stb_q == STB_LAST) begin
          state_d = ST_LOCKED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_FAIL;
          set_to  = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (!pllon_q) begin
          state_d = ST_OFF;
        end else if (!lock_s) begin
          state_d = ST_LOCKING;
        end else if (swreq_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_LOCKING;
          set_ll  = 1'b1;
        end else if (!swreq_q) begin
          state_d = ST_LOCKED;
        end
      end
      ST_FAIL: begin
        if (!timeout_q) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Bus-visible registers, status flags and output decodes
  always_comb begin
    boot_done_d = 1'b1;
    remap_d     = remap_q;
    if (!boot_done_q) remap_d = CFG_BOOT;
    if (we && sel_remap && be[0]) remap_d = HWDATA[0];

    rstinfo_d = (rstinfo_q & ~rst_clr) | RST_SRC;

    pllon_d = pllon_q;
    swreq_d = swreq_q;
    if (we && sel_ctl && be[0] && state_q != ST_FAIL &&
        (HWDATA[0] || !clk_sel_q)) begin
      pllon_d = HWDATA[0];
    end
    if (we && sel_ctl && be[1]) swreq_d = HWDATA[8];

    timeout_d  = timeout_q;
    lockloss_d = lockloss_q;
    if (we && sel_stat && be[1]) begin
      if (HWDATA[8]) timeout_d  = 1'b0;
      if (HWDATA[9]) lockloss_d = 1'b0;
    end
    if (set_to) begin
      timeout_d = 1'b1;
      pllon_d   = 1'b0;
    end
    if (set_ll) begin
      lockloss_d = 1'b1;
      swreq_d    = 1'b0;
    end

    irq_d     = timeout_d | lockloss_d;
    pll_en_d  = (state_d == ST_LOCKING) || (state_d == ST_LOCKED) ||
                (state_d == ST_RUN);
    clk_sel_d = (state_d == ST_RUN);
    sync1_d   = PLL_LOCK;
    sync2_d   = sync1_q;
  end

  // State register with synchronous reset
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      act_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      boot_done_q <= 1'b0;
      remap_q     <= 1'b0;
      rstinfo_q   <= '0;
      pllon_q     <= 1'b0;
      swreq_q     <= 1'b0;
      timeout_q   <= 1'b0;
      lockloss_q  <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      stb_q       <= '0;
      pll_en_q    <= 1'b0;
      clk_sel_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      act_q       <= act_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      boot_done_q <= boot_done_d;
      remap_q     <= remap_d;
      rstinfo_q   <= rstinfo_d;
      pllon_q     <= pllon_d;
      swreq_q     <= swreq_d;
      timeout_q   <= timeout_d;
      lockloss_q  <= lockloss_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stb_q       <= stb_d;
      pll_en_q    <= pll_en_d;
      clk_sel_q   <= clk_sel_d;
      irq_q       <= irq_d;
    end
  end

endmodule

// File: tb/tb_mcu_rstclk_ctrl.sv
// tb_mcu_rstclk_ctrl: directed bench for mcu_rstclk_ctrl.
// Inputs change and outputs are sampled on the falling edge.
module tb_mcu_rstclk_ctrl;

  logic        clk = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic        HREADY = 1'b1;
  logic        HWRITE = 1'b0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'd2;
  logic [11:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic        HREADYOUT, HRESP;
  logic [31:0] HRDATA;
  logic        CFG_BOOT = 1'b0;
  logic [2:0]  RST_SRC = '0;
  logic        PLL_LOCK = 1'b0;
  logic        PLL_EN, CLK_SEL, REMAP, IRQ;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] rdv;

  always #5 clk = ~clk;

  mcu_rstclk_ctrl #(
    .ADDR_W(12), .NUM_RST_SRC(3), .LOCK_TIMEOUT(1024), .LOCK_STABLE(4)
  ) dut (
    .HCLK(clk), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY),
    .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HADDR(HADDR),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .CFG_BOOT(CFG_BOOT), .RST_SRC(RST_SRC),
    .PLL_LOCK(PLL_LOCK), .PLL_EN(PLL_EN), .CLK_SEL(CLK_SEL),
    .REMAP(REMAP), .IRQ(IRQ)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // write lands on the edge before this task returns
  task automatic ahb_wr(input logic [11:0] a, input logic [2:0] sz,
                        input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a; HSIZE = sz;
    @(negedge clk);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(negedge clk);
  endtask

  task automatic ahb_rd(input logic [11:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a; HSIZE = 3'd2;
    @(negedge clk);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic poll_start(input logic [11:0] a);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a; HSIZE = 3'd2;
    @(negedge clk);
  endtask

  task automatic poll_stop();
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; CFG_BOOT = 1'b1;
    tick(3);
    nvec++;
    if ({REMAP, PLL_EN, CLK_SEL, IRQ} !== 4'b0000) begin
      nerr++;
      $display("FAIL rst_outs: got %b want 0000",
               {REMAP, PLL_EN, CLK_SEL, IRQ});
    end
    nvec++;
    if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'd0}) begin
      nerr++;
      $display("FAIL rst_bus: got rdy=%b resp=%b rdata=%h want 1 0 0",
               HREADYOUT, HRESP, HRDATA);
    end
    HRESET = 1'b0;
    nvec++;
    if (REMAP !== 1'b0) begin
      nerr++; $display("FAIL remap_pre_edge: got %b want 0", REMAP);
    end
    tick(1);
    nvec++;
    if (REMAP !== 1'b1) begin
      nerr++; $display("FAIL remap_boot: got %b want 1", REMAP);
    end
    ahb_rd(12'h000, rdv);
    nvec++;
    if (rdv !== 32'h1) begin
      nerr++; $display("FAIL remap_rd1: got %h want 1", rdv);
    end
    ahb_wr(12'h000, 3'd0, 32'h0);
    nvec++;
    if (REMAP !== 1'b0) begin
      nerr++; $display("FAIL remap_wr0: got %b want 0", REMAP);
    end
    ahb_rd(12'h000, rdv);
    nvec++;
    if (rdv !== 32'h0) begin
      nerr++; $display("FAIL remap_rd0: got %h want 0", rdv);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] vals;
    vals = 2'b10;
    for (int i = 0; i < 2; i++) begin
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
      HADDR = 12'h000; HSIZE = 3'd2;
      @(negedge clk);
      HWDATA = {31'd0, vals[i]}; HWRITE = 1'b0;
      @(negedge clk);
      HSEL = 1'b0; HTRANS = 2'b00;
      nvec++;
      if (HRDATA !== {31'd0, vals[i]}) begin
        nerr++;
        $display("FAIL b2b_rd%0d: got %h want %h", i, HRDATA, vals[i]);
      end
    end
  endtask

  task automatic test_rstinfo();
    RST_SRC = 3'b010;
    tick(1);
    RST_SRC = 3'b000;
    ahb_rd(12'h004, rdv);
    nvec++;
    if (rdv !== 32'h2) begin
      nerr++; $display("FAIL rst_set: got %h want 2", rdv);
    end
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
    HADDR = 12'h004; HSIZE = 3'd2;
    @(negedge clk);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HWDATA = 32'h2; RST_SRC = 3'b010;
    @(negedge clk);
    RST_SRC = 3'b000;
    ahb_rd(12'h004, rdv);
    nvec++;
    if (rdv !== 32'h2) begin
      nerr++; $display("FAIL rst_set_wins: got %h want 2", rdv);
    end
    ahb_wr(12'h004, 3'd2, 32'h2);
    ahb_rd(12'h004, rdv);
    nvec++;
    if (rdv !== 32'h0) begin
      nerr++; $display("FAIL rst_w1c: got %h want 0", rdv);
    end
    RST_SRC = 3'b101;
    tick(1);
    RST_SRC = 3'b000;
    ahb_rd(12'h004, rdv);
    nvec++;
    if (rdv !== 32'h5) begin
      nerr++; $display("FAIL rst_set2: got %h want 5", rdv);
    end
    ahb_wr(12'h004, 3'd0, 32'h4);
    ahb_rd(12'h004, rdv);
    nvec++;
    if (rdv !== 32'h1) begin
      nerr++; $display("FAIL rst_w1c_b0: got %h want 1", rdv);
    end
    ahb_wr(12'h005, 3'd0, 32'h0000_0101);
    ahb_rd(12'h004, rdv);
    nvec++;
    if (rdv !== 32'h1) begin
      nerr++; $display("FAIL rst_lane1: got %h want 1", rdv);
    end
    ahb_wr(12'h004, 3'd0, 32'h1);
    ahb_rd(12'h004, rdv);
    nvec++;
    if (rdv !== 32'h0) begin
      nerr++; $display("FAIL rst_clr_all: got %h want 0", rdv);
    end
  endtask

  task automatic test_pll_lock();
    PLL_LOCK = 1'b0;
    ahb_wr(12'h008, 3'd2, 32'h1);
    nvec++;
    if (PLL_EN !== 1'b0) begin
      nerr++; $display("FAIL en_wr_edge: got %b want 0", PLL_EN);
    end
    tick(1);
    nvec++;
    if (PLL_EN !== 1'b1) begin
      nerr++; $display("FAIL en_locking: got %b want 1", PLL_EN);
    end
    poll_start(12'h00C);
    nvec++;
    if (HRDATA !== 32'h4) begin
      nerr++; $display("FAIL stat_locking: got %h want 4", HRDATA);
    end
    tick(6);
    PLL_LOCK = 1'b1;
    tick(1);
    nvec++;
    if (HRDATA !== 32'h4) begin
      nerr++; $display("FAIL sync_1edge: got %h want 4", HRDATA);
    end
    tick(1);
    nvec++;
    if (HRDATA !== 32'h5) begin
      nerr++; $display("FAIL sync_2edge: got %h want 5", HRDATA);
    end
    tick(3);
    nvec++;
    if (HRDATA !== 32'h5) begin
      nerr++; $display("FAIL stable_5edge: got %h want 5", HRDATA);
    end
    tick(1);
    nvec++;
    if (HRDATA !== 32'h9) begin
      nerr++; $display("FAIL locked_6edge: got %h want 9", HRDATA);
    end
    poll_stop();
    ahb_wr(12'h00A, 3'd1, 32'hFFFF_FFFF);
    tick(1);
    ahb_rd(12'h008, rdv);
    nvec++;
    if (rdv !== 32'h1 || CLK_SEL !== 1'b0) begin
      nerr++;
      $display("FAIL half_0a: got ctl=%h sel=%b want 1 0", rdv, CLK_SEL);
    end
    ahb_wr(12'h009, 3'd0, 32'h0000_0100);
    nvec++;
    if (CLK_SEL !== 1'b0) begin
      nerr++; $display("FAIL sel_wr_edge: got %b want 0", CLK_SEL);
    end
    tick(1);
    nvec++;
    if ({CLK_SEL, PLL_EN} !== 2'b11) begin
      nerr++;
      $display("FAIL sel_run: got %b want 11", {CLK_SEL, PLL_EN});
    end
    ahb_rd(12'h008, rdv);
    nvec++;
    if (rdv !== 32'h101) begin
      nerr++; $display("FAIL ctl_run: got %h want 101", rdv);
    end
    ahb_rd(12'h00C, rdv);
    nvec++;
    if (rdv !== 32'hF) begin
      nerr++; $display("FAIL stat_run: got %h want f", rdv);
    end
    ahb_wr(12'h008, 3'd0, 32'h0);
    tick(2);
    ahb_rd(12'h008, rdv);
    nvec++;
    if (rdv !== 32'h101 || CLK_SEL !== 1'b1) begin
      nerr++;
      $display("FAIL pllon_off_ign: got ctl=%h sel=%b want 101 1",
               rdv, CLK_SEL);
    end
  endtask

  task automatic test_lock_loss();
    poll_start(12'h00C);
    PLL_LOCK = 1'b0;
    tick(2);
    nvec++;
    if (CLK_SEL !== 1'b1 || HRDATA !== 32'hE) begin
      nerr++;
      $display("FAIL loss_2edge: got sel=%b stat=%h want 1 e",
               CLK_SEL, HRDATA);
    end
    tick(1);
    nvec++;
    if ({CLK_SEL, IRQ, PLL_EN} !== 3'b011 || HRDATA !== 32'h204) begin
      nerr++;
      $display("FAIL loss_3edge: got sel/irq/en=%b stat=%h want 011 204",
               {CLK_SEL, IRQ, PLL_EN}, HRDATA);
    end
    poll_stop();
    ahb_rd(12'h008, rdv);
    nvec++;
    if (rdv !== 32'h1) begin
      nerr++; $display("FAIL loss_swreq: got %h want 1", rdv);
    end
    PLL_LOCK = 1'b1;
    tick(10);
    ahb_rd(12'h00C, rdv);
    nvec++;
    if (rdv !== 32'h209 || CLK_SEL !== 1'b0) begin
      nerr++;
      $display("FAIL relock: got stat=%h sel=%b want 209 0", rdv, CLK_SEL);
    end
    ahb_wr(12'h00C, 3'd2, 32'h200);
    nvec++;
    if (IRQ !== 1'b0) begin
      nerr++; $display("FAIL loss_w1c_irq: got %b want 0", IRQ);
    end
    ahb_rd(12'h00C, rdv);
    nvec++;
    if (rdv !== 32'h9) begin
      nerr++; $display("FAIL loss_w1c_stat: got %h want 9", rdv);
    end
    ahb_wr(12'h008, 3'd2, 32'h0);
    tick(1);
    nvec++;
    if (PLL_EN !== 1'b0) begin
      nerr++; $display("FAIL pll_off: got %b want 0", PLL_EN);
    end
  endtask

  task automatic test_timeout();
    PLL_LOCK = 1'b0;
    tick(3);
    ahb_wr(12'h008, 3'd2, 32'h1);
    tick(1);
    nvec++;
    if (PLL_EN !== 1'b1) begin
      nerr++; $display("FAIL to_start: got %b want 1", PLL_EN);
    end
    tick(1023);
    nvec++;
    if ({PLL_EN, IRQ} !== 2'b10) begin
      nerr++; $display("FAIL to_before: got %b want 10", {PLL_EN, IRQ});
    end
    tick(1);
    nvec++;
    if ({PLL_EN, IRQ} !== 2'b01) begin
      nerr++; $display("FAIL to_fail: got %b want 01", {PLL_EN, IRQ});
    end
    ahb_rd(12'h00C, rdv);
    nvec++;
    if (rdv !== 32'h110) begin
      nerr++; $display("FAIL to_stat: got %h want 110", rdv);
    end
    ahb_rd(12'h008, rdv);
    nvec++;
    if (rdv !== 32'h0) begin
      nerr++; $display("FAIL to_pllon: got %h want 0", rdv);
    end
    ahb_wr(12'h008, 3'd2, 32'h1);
    ahb_rd(12'h008, rdv);
    nvec++;
    if (rdv !== 32'h0) begin
      nerr++; $display("FAIL fail_wr_ign: got %h want 0", rdv);
    end
    ahb_wr(12'h00C, 3'd2, 32'h100);
    nvec++;
    if (IRQ !== 1'b0) begin
      nerr++; $display("FAIL to_w1c_irq: got %b want 0", IRQ);
    end
    ahb_rd(12'h00C, rdv);
    nvec++;
    if (rdv !== 32'h0 || PLL_EN !== 1'b0) begin
      nerr++;
      $display("FAIL to_off: got stat=%h en=%b want 0 0", rdv, PLL_EN);
    end
  endtask

  task automatic test_unmapped();
    ahb_rd(12'h010, rdv);
    nvec++;
    if (rdv !== 32'h0) begin
      nerr++; $display("FAIL unmap_rd: got %h want 0", rdv);
    end
    ahb_wr(12'h010, 3'd2, 32'h0);
    ahb_wr(12'h018, 3'd2, 32'hFFFF_FFFF);
    tick(1);
    nvec++;
    if ({REMAP, PLL_EN} !== 2'b10) begin
      nerr++;
      $display("FAIL unmap_wr: got %b want 10", {REMAP, PLL_EN});
    end
    ahb_rd(12'hFFC, rdv);
    nvec++;
    if (rdv !== 32'h0) begin
      nerr++; $display("FAIL unmap_top: got %h want 0", rdv);
    end
  endtask

  task automatic test_mid_reset();
    CFG_BOOT = 1'b0;
    RST_SRC = 3'b100;
    tick(1);
    RST_SRC = 3'b000;
    ahb_wr(12'h008, 3'd2, 32'h1);
    tick(2);
    nvec++;
    if (PLL_EN !== 1'b1) begin
      nerr++; $display("FAIL mid_pre: got %b want 1", PLL_EN);
    end
    HRESET = 1'b1;
    tick(1);
    nvec++;
    if ({REMAP, PLL_EN, CLK_SEL, IRQ} !== 4'b0000) begin
      nerr++;
      $display("FAIL mid_rst: got %b want 0000",
               {REMAP, PLL_EN, CLK_SEL, IRQ});
    end
    HRESET = 1'b0;
    tick(2);
    ahb_rd(12'h004, rdv);
    nvec++;
    if (rdv !== 32'h0) begin
      nerr++; $display("FAIL mid_rstinfo: got %h want 0", rdv);
    end
    ahb_rd(12'h008, rdv);
    nvec++;
    if (rdv !== 32'h0 || REMAP !== 1'b0 || PLL_EN !== 1'b0) begin
      nerr++;
      $display("FAIL mid_ctl: got ctl=%h remap=%b en=%b want 0 0 0",
               rdv, REMAP, PLL_EN);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_rstinfo();
    test_pll_lock();
    test_lock_loss();
    test_timeout();
    test_unmapped();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
